// File: rtl/op_checker.sv
// op_checker: walks all {a,b,c,d[2:0]} combinations up to LAST_VEC. For each
// one it presents the stimulus to an external DUT, waits for the DUT's 16-bit
// response, compares it with the locally computed logic-op results and keeps
// a failure summary.
//
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   start                     one-cycle pulse; honoured only in IDLE or DONE
//   stim_valid/stim_ready     stimulus handshake
//   stim_a, stim_b, stim_c    operand bits (idx[5], idx[4], idx[3])
//   stim_d                    3-bit operand (idx[2:0]; changes fastest)
//   resp_valid, resp          DUT result; this block is always ready
//   busy, done, pass          run status; pass is meaningful while done=1
//   err_count                 failing vectors, saturating at 255
//   first_idx, first_mask     index and expected^actual of the first failure
//   timeout_err               sticky: some response never arrived
module op_checker #(
  parameter int TIMEOUT  = 15,  // WAIT cycles allowed, 1..255
  parameter int LAST_VEC = 63   // final vector index, 0..63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        stim_valid,
  input  logic        stim_ready,
  output logic        stim_a,
  output logic        stim_b,
  output logic        stim_c,
  output logic [2:0]  stim_d,
  input  logic        resp_valid,
  input  logic [15:0] resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [5:0]  first_idx,
  output logic [15:0] first_mask,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [5:0] LAST_IDX   = 6'(LAST_VEC);

  state_t      state_reg;
  logic [5:0]  idx_reg;
  logic [7:0]  wait_cnt_reg;
  logic [15:0] resp_reg;
  logic        vec_timeout_reg;  // current vector ended by timeout

  logic        va, vb, vc;
  logic [2:0]  vd;
  logic [15:0] expected;
  logic [15:0] mism_raw;
  logic [15:0] mism;
  logic        failed;
  logic [7:0]  err_count_next;
  logic [5:0]  idx_next;

  // Reference results always come from the vector currently being processed.
  assign va = idx_reg[5];
  assign vb = idx_reg[4];
  assign vc = idx_reg[3];
  assign vd = idx_reg[2:0];

  assign expected = {
    vd[1],          // [15]
    ~^vd,           // [14]
    ~|vd,           // [13]
    ~&vd,           // [12]
    ^vd,            // [11]
    |vd,            // [10]
    &vd,            // [9]
    va ? vb : vc,   // [8]
    va == vb,       // [7]
    va & ~vb,       // [6] a > b
    ~va & vb,       // [5] a < b
    ~(va ^ vb),     // [4]
    ~(va & vb),     // [3]
    va | vb,        // [2]
    va & vb,        // [1]
    va ^ vb         // [0]
  };

  // Case inequality makes an X or Z response bit count as a mismatch.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cmp
      assign mism_raw[gi] = (resp_reg[gi] !== expected[gi]);
    end
  endgenerate

  // A timed-out vector has no meaningful response; every bit is reported bad.
  assign mism     = vec_timeout_reg ? 16'hFFFF : mism_raw;
  assign failed   = |mism;
  assign idx_next = idx_reg + 6'd1;

  always_comb begin
    err_count_next = err_count;
    if (failed && (err_count != 8'hFF))
      err_count_next = err_count + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      wait_cnt_reg    <= '0;
      resp_reg        <= '0;
      vec_timeout_reg <= 1'b0;
      stim_valid      <= 1'b0;
      stim_a          <= 1'b0;
      stim_b          <= 1'b0;
      stim_c          <= 1'b0;
      stim_d          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_idx       <= '0;
      first_mask      <= '0;
      timeout_err     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg   <= S_ISSUE;
            idx_reg     <= '0;
            stim_valid  <= 1'b1;
            {stim_a, stim_b, stim_c, stim_d} <= 6'd0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            first_idx   <= '0;
            first_mask  <= '0;
            timeout_err <= 1'b0;
          end
        end

        S_ISSUE: begin
          // stim_* are only rewritten when a new vector is issued, so they
          // stay put however long the DUT stalls the handshake.
          if (stim_valid && stim_ready) begin
            state_reg       <= S_WAIT;
            stim_valid      <= 1'b0;
            wait_cnt_reg    <= '0;
            vec_timeout_reg <= 1'b0;
          end
        end

        S_WAIT: begin
          if (resp_valid) begin
            resp_reg  <= resp;
            state_reg <= S_CHECK;
          end else if (wait_cnt_reg == WAIT_LIMIT) begin
            // This is the TIMEOUT-th cycle spent waiting.
            timeout_err     <= 1'b1;
            vec_timeout_reg <= 1'b1;
            state_reg       <= S_CHECK;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        S_CHECK: begin
          err_count <= err_count_next;
          // err_count saturates rather than wrapping, so zero means no
          // failure has been recorded yet in this run.
          if (failed && (err_count == 8'd0)) begin
            first_idx  <= idx_reg;
            first_mask <= mism;
          end
          if (idx_reg == LAST_IDX) begin
            state_reg <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_count_next == 8'd0);
          end else begin
            state_reg  <= S_ISSUE;
            idx_reg    <= idx_next;
            stim_valid <= 1'b1;
            {stim_a, stim_b, stim_c, stim_d} <= idx_next;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/op_checker.md
OP_CHECKER -- requirements
Module: op_checker

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, which is the number of WAIT cycles allowed before a response is declared missing (legal range 1..255).
REQ-002 SHALL have parameter LAST_VEC, default 63, which is the final vector index (legal range 0..63).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run; ignored unless in IDLE or DONE.
- stim_valid  out  1  stimulus vector is presented.
- stim_ready  in  1  DUT accepts the stimulus.
- stim_a, stim_b, stim_c  out  1 each  operand bits.
- stim_d  out  3  vector operand.
- resp_valid  in  1  DUT result is presented; this block is always ready.
- resp  in  16  DUT result bits (bit map in REQ-010).
- busy  out  1  a run is in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  valid while done=1; 1 when err_count==0.
- err_count  out  8  number of failing vectors; saturates at 255.
- first_idx  out  6  index of the first failing vector.
- first_mask  out  16  XOR of expected and actual results for the first failing vector.
- timeout_err  out  1  sticky flag; set when a response never arrived.

Function
REQ-005 The vector index idx SHALL be 6 bits, mapped as {a,b,c,d[2:0]} = idx[5], idx[4], idx[3], idx[2:0], so that d varies fastest.
REQ-006 SHALL implement the states IDLE, ISSUE, WAIT, CHECK and DONE.
REQ-007 On start in IDLE or DONE, the block SHALL enter ISSUE with idx=0 and SHALL clear err_count, first_idx, first_mask, timeout_err and done.
REQ-008 In ISSUE, stim_valid SHALL be 1 and stim_* SHALL be driven from idx.
- The stim_* outputs SHALL stay stable until the cycle in which stim_valid&&stim_ready is sampled.
- That handshake moves the block to WAIT with the wait counter cleared.
REQ-009 In WAIT, stim_valid SHALL be 0.
- resp_valid=1 SHALL capture resp and move the block to CHECK.
- Otherwise the wait counter SHALL increment.
- When the counter reaches TIMEOUT: timeout_err SHALL be set, the vector SHALL count as a failure with first_mask = 16'hFFFF, and the block SHALL move to CHECK.
- resp_valid outside WAIT SHALL be ignored.
REQ-010 Expected bits, computed from the issued vector:
- [0] a^b
- [1] a&b
- [2] a|b
- [3] ~(a&b)
- [4] ~(a^b)
- [5] a<b
- [6] a>b
- [7] a==b
- [8] a?b:c
- [9] &d
- [10] |d
- [11] ^d
- [12] ~&d
- [13] ~|d
- [14] ~^d
- [15] d[1]
REQ-011 CHECK SHALL last exactly one cycle.
- The check SHALL compute mism = expected ^ captured resp.
- Any X/Z bit in resp SHALL count as a mismatch.
- A nonzero mism SHALL increment err_count (saturating).
- On the first failure only, the block SHALL latch first_idx=idx and first_mask=mism.
REQ-012 From CHECK, the block SHALL go to DONE if idx==LAST_VEC; otherwise it SHALL increment idx and go to ISSUE.
REQ-013 In DONE: done=1, busy=0, and pass=(err_count==0); results SHALL hold until the next start.
REQ-014 busy SHALL be 1 in ISSUE, WAIT and CHECK.
REQ-015 The minimum per-vector latency SHALL be 3 cycles (ISSUE, WAIT, CHECK) when stim_ready and resp_valid are asserted immediately.
REQ-016 start asserted during ISSUE, WAIT or CHECK SHALL have no effect.

Reset
REQ-017 Reset SHALL force state IDLE, idx=0 and every output to 0, including stim_*.
REQ-018 Reset asserted mid-run SHALL abort the run immediately; no partial result SHALL survive.
REQ-019 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-020 Ideal DUT, stim_ready and resp_valid tied to 1, start pulsed once -> 64 vectors in 192 cycles; done=1, pass=1, err_count=0.
REQ-021 DUT with resp[11] stuck at 0 -> err_count=32, first_idx=1, first_mask=16'h0800, pass=0.
REQ-022 resp_valid withheld for idx=5 -> after 15 WAIT cycles timeout_err=1, first_idx=5, first_mask=16'hFFFF; run still finishes with err_count=1.
REQ-023 stim_ready held low for 10 cycles at idx=0 -> stim_valid=1 and stim_* stay 0 throughout; no idx advance.
REQ-024 Reset pulsed while in WAIT at idx=20 -> all outputs 0, state IDLE; a new start runs a clean pass.
REQ-025 start pulsed mid-run and LAST_VEC=7 -> the mid-run start is ignored; the LAST_VEC=7 run finishes after 8 vectors.
